// File: rtl/common.sv
// Shared types and helpers for channel-scan sequencing.
// next_enabled_ch is a circular priority search usable by any scanner.
package common;

   typedef enum logic {SEQ_IDLE, SEQ_SCAN} seq_state_t;

   localparam int MAX_CH = 64;

   // Returns {found, index}; search starts at `start` inclusive.
   function automatic logic [6:0] next_enabled_ch(
      input logic [MAX_CH-1:0] mask,
      input logic [5:0]        start,
      input logic              dir,
      input int                n
   );
      logic       found;
      logic [5:0] idx;
      int         c;
      found = 1'b0;
      idx   = start;
      for (int i = 0; i < MAX_CH; i++) begin
         c = dir ? int'(start) - i : int'(start) + i;
         if (c < 0)
            c = c + n;
         else if (c >= n)
            c = c - n;
         if (i < n && !found && mask[c[5:0]]) begin
            found = 1'b1;
            idx   = c[5:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/chan_scan_seq_if.sv
// Control and status bundle between a scan controller and chan_scan_seq.
// master drives enables/mask/dwell; slave returns the select stream.
interface chan_scan_seq_if #(
   parameter int NUM_CH  = 4,
   parameter int DWELL_W = 8
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic               en;
   logic               sync_clr;
   logic [NUM_CH-1:0]  mask;
   logic [DWELL_W-1:0] dwell;
   logic               dir;
   logic               hold;
   logic [SEL_W-1:0]   select;
   logic               select_valid;
   logic               wrap;

   modport master (
      output en, sync_clr, mask, dwell, dir, hold,
      input  select, select_valid, wrap
   );

   modport slave (
      input  en, sync_clr, mask, dwell, dir, hold,
      output select, select_valid, wrap
   );

endinterface

// File: rtl/chan_next_finder.sv
// Combinational next-enabled-channel search in either direction.
// incl=1 searches from cur inclusive; incl=0 starts one step past cur.
module chan_next_finder
   import common::*;
#(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              dir,
   input  logic              incl,
   output logic [SEL_W-1:0]  nxt,
   output logic              found,
   output logic              wrap
);

   logic [5:0] cur6;
   logic [5:0] start;
   logic [6:0] res;

   always_comb begin
      cur6 = 6'(cur);
      if (incl)
         start = cur6;
      else if (dir)
         start = (cur6 == 6'd0) ? 6'(NUM_CH - 1) : cur6 - 6'd1;
      else
         start = (cur6 == 6'(NUM_CH - 1)) ? 6'd0 : cur6 + 6'd1;
      res   = next_enabled_ch(64'(mask), start, dir, NUM_CH);
      found = res[6];
      nxt   = SEL_W'(res[5:0]);
      // A lone enabled channel re-selects itself and so counts as a wrap.
      wrap  = dir ? (nxt >= cur) : (nxt <= cur);
   end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel-select sequencer: steps select over enabled channels,
// dwelling dwell+1 cycles on each, with hold, direction and wrap pulse.
module chan_scan_seq
   import common::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int DWELL_W = 8,
   localparam int SEL_W   = $clog2(NUM_CH)
) (
   input  logic             clk,
   input  logic             rstN,
   chan_scan_seq_if.slave   bus
);

   seq_state_t         state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwl_q, dwl_d;

   logic [SEL_W-1:0]   first_start;
   logic [SEL_W-1:0]   first_sel;
   logic               first_found;
   logic               first_wrap_unused;
   logic [SEL_W-1:0]   adv_sel;
   logic               adv_found;
   logic               adv_wrap;
   logic               adv;

   assign first_start = bus.dir ? SEL_W'(NUM_CH - 1) : '0;

   chan_next_finder #(.NUM_CH(NUM_CH)) u_first (
      .mask  (bus.mask),
      .cur   (first_start),
      .dir   (bus.dir),
      .incl  (1'b1),
      .nxt   (first_sel),
      .found (first_found),
      .wrap  (first_wrap_unused)
   );

   chan_next_finder #(.NUM_CH(NUM_CH)) u_adv (
      .mask  (bus.mask),
      .cur   (sel_q),
      .dir   (bus.dir),
      .incl  (1'b0),
      .nxt   (adv_sel),
      .found (adv_found),
      .wrap  (adv_wrap)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;
      dwl_d   = dwl_q;
      adv     = 1'b0;
      if (bus.sync_clr) begin
         state_d = SEQ_IDLE;
         sel_d   = '0;
         valid_d = 1'b0;
         cnt_d   = '0;
         dwl_d   = '0;
      end else begin
         unique case (state_q)
            SEQ_IDLE: begin
               valid_d = 1'b0;
               if (bus.en && first_found) begin
                  state_d = SEQ_SCAN;
                  sel_d   = first_sel;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  dwl_d   = bus.dwell;
               end
            end
            SEQ_SCAN: begin
               // adv_found is low exactly when the mask is empty.
               if (!bus.en || !adv_found) begin
                  state_d = SEQ_IDLE;
                  valid_d = 1'b0;
               end else if (!bus.mask[sel_q]) begin
                  adv = 1'b1;
               end else if (bus.hold) begin
                  cnt_d = cnt_q;
               end else if (cnt_q == dwl_q) begin
                  adv = 1'b1;
               end else begin
                  cnt_d = cnt_q + DWELL_W'(1);
               end
               if (adv) begin
                  sel_d   = adv_sel;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  dwl_d   = bus.dwell;
                  wrap_d  = adv_wrap;
               end
            end
            default: state_d = SEQ_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= SEQ_IDLE;
         sel_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
         dwl_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         dwl_q   <= dwl_d;
      end
   end

   assign bus.select       = sel_q;
   assign bus.select_valid = valid_q;
   assign bus.wrap         = wrap_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Scoreboard bench for chan_scan_seq: directed scenarios then random
// traffic, each cycle predicted by a channel/remaining-cycles model.
module tb_chan_scan_seq;

   localparam int N  = 4;
   localparam int DW = 8;

   logic clk  = 1'b0;
   logic rstN = 1'b0;

   always #5 clk = ~clk;

   chan_scan_seq_if #(.NUM_CH(N), .DWELL_W(DW)) bus ();

   chan_scan_seq #(.NUM_CH(N), .DWELL_W(DW)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   typedef struct {
      int sel;
      int vld;
      int wrp;
      int tag;
   } exp_t;

   exp_t exp_q[$];
   int   hist[8][$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: scanning flag, channel, cycles left on channel.
   bit   m_scan;
   int   m_sel;
   int   m_rem;
   int   m_vld;
   int   m_wrp;

   logic [3:0] rm;
   bit         rd;

   function automatic void check(string name, int act, int want);
      n_chk++;
      if (act == want)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
   endfunction

   function automatic int first_ch(logic [3:0] msk, bit d);
      int c;
      for (int k = 0; k < N; k++) begin
         c = d ? N - 1 - k : k;
         if (msk[c]) return c;
      end
      return 0;
   endfunction

   function automatic int next_ch(int cur, logic [3:0] msk, bit d);
      int c;
      for (int k = 1; k <= N; k++) begin
         c = d ? (cur - k + N) % N : (cur + k) % N;
         if (msk[c]) return c;
      end
      return cur;
   endfunction

   function automatic void model_adv(logic [3:0] msk, bit d, int dw);
      int nw;
      nw    = next_ch(m_sel, msk, d);
      m_wrp = d ? int'(nw >= m_sel) : int'(nw <= m_sel);
      m_sel = nw;
      m_rem = dw;
      m_vld = 1;
   endfunction

   function automatic void model_tick();
      logic [3:0] msk;
      int         dw;
      msk   = bus.mask;
      dw    = int'(bus.dwell);
      m_wrp = 0;
      if (!rstN || bus.sync_clr) begin
         m_scan = 0;
         m_sel  = 0;
         m_rem  = 0;
         m_vld  = 0;
      end else if (!m_scan) begin
         m_vld = 0;
         if (bus.en && msk != 4'h0) begin
            m_scan = 1;
            m_sel  = first_ch(msk, bus.dir);
            m_rem  = dw;
            m_vld  = 1;
         end
      end else if (!bus.en || msk == 4'h0) begin
         m_scan = 0;
         m_vld  = 0;
      end else if (!msk[m_sel]) begin
         model_adv(msk, bus.dir, dw);
      end else if (bus.hold) begin
         m_rem = m_rem;
      end else if (m_rem == 0) begin
         model_adv(msk, bus.dir, dw);
      end else begin
         m_rem = m_rem - 1;
      end
   endfunction

   task automatic step(input bit r, input bit e, input bit c,
                       input logic [3:0] m, input int dw,
                       input bit d, input bit h, input int tag);
      exp_t x;
      @(negedge clk);
      rstN         = r;
      bus.en       = e;
      bus.sync_clr = c;
      bus.mask     = m;
      bus.dwell    = DW'(dw);
      bus.dir      = d;
      bus.hold     = h;
      model_tick();
      x.sel = m_sel;
      x.vld = m_vld;
      x.wrp = m_wrp;
      x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic drain();
      @(posedge clk);
      #2;
   endtask

   task automatic check_seq(input int tag, input int want[$],
                            input string name);
      int act;
      check({name, "_len"}, hist[tag].size(), want.size());
      for (int i = 0; i < want.size(); i++) begin
         act = (i < hist[tag].size()) ? hist[tag][i] : -1;
         check($sformatf("%s[%0d]", name, i), act, want[i]);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("select", int'(bus.select), x.sel);
            check("select_valid", int'(bus.select_valid), x.vld);
            check("wrap", int'(bus.wrap), x.wrp);
            if (x.tag > 0)
               hist[x.tag].push_back(int'(bus.select));
         end
      end
   end

   initial begin : driver
      bus.en       = 1'b0;
      bus.sync_clr = 1'b0;
      bus.mask     = 4'h0;
      bus.dwell    = '0;
      bus.dir      = 1'b0;
      bus.hold     = 1'b0;
      m_scan = 0; m_sel = 0; m_rem = 0; m_vld = 0; m_wrp = 0;
      rm = 4'hF;
      rd = 1'b0;
      #2;
      check("rst_select", int'(bus.select), 0);
      check("rst_valid", int'(bus.select_valid), 0);
      check("rst_wrap", int'(bus.wrap), 0);

      repeat (13) step(1, 1, 0, 4'hF, 2, 0, 0, 1);
      step(1, 0, 0, 4'hF, 2, 0, 0, 0);
      drain();
      check_seq(1, '{0,0,0,1,1,1,2,2,2,3,3,3,0}, "asc");

      repeat (6) step(1, 1, 0, 4'hA, 0, 0, 0, 2);
      step(1, 0, 0, 4'hA, 0, 0, 0, 0);
      drain();
      check_seq(2, '{1,3,1,3,1,3}, "masked");

      repeat (6) step(1, 1, 0, 4'hF, 0, 1, 0, 3);
      step(1, 1, 0, 4'hF, 0, 0, 0, 3);
      step(1, 0, 0, 4'hF, 0, 0, 0, 0);
      drain();
      check_seq(3, '{3,2,1,0,3,2,3}, "desc");

      repeat (8) step(1, 1, 0, 4'hF, 5, 0, 0, 4);
      step(1, 1, 0, 4'hD, 5, 0, 0, 4);
      step(1, 0, 0, 4'hD, 5, 0, 0, 0);
      repeat (6) step(1, 1, 0, 4'h4, 1, 0, 0, 5);
      step(1, 0, 0, 4'h4, 1, 0, 0, 0);
      drain();
      check_seq(4, '{0,0,0,0,0,0,1,1,2}, "drop");
      check_seq(5, '{2,2,2,2,2,2}, "single");

      step(1, 1, 0, 4'hF, 3, 0, 0, 6);
      step(1, 1, 0, 4'hF, 3, 0, 0, 6);
      repeat (4) step(1, 1, 0, 4'hF, 3, 0, 1, 6);
      repeat (3) step(1, 1, 0, 4'hF, 3, 0, 0, 6);
      step(1, 0, 0, 4'hF, 3, 0, 0, 6);
      step(1, 1, 0, 4'hF, 3, 0, 0, 6);
      repeat (4) step(1, 1, 0, 4'hF, 3, 0, 0, 0);
      drain();
      check_seq(6, '{0,0,0,0,0,0,0,0,1,1,0}, "hold");

      @(posedge clk);
      #3;
      rstN = 1'b0;
      #1;
      check("arst_select", int'(bus.select), 0);
      check("arst_valid", int'(bus.select_valid), 0);
      check("arst_wrap", int'(bus.wrap), 0);
      step(0, 1, 0, 4'hF, 0, 0, 0, 0);
      repeat (4) step(1, 1, 0, 4'hF, 0, 0, 0, 7);
      step(1, 1, 1, 4'hF, 0, 0, 0, 7);
      step(1, 1, 0, 4'hF, 0, 0, 0, 7);
      drain();
      check_seq(7, '{0,1,2,3,0,0}, "clear");

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 4) == 0) rm = 4'($urandom);
         if ($urandom_range(0, 9) == 0) rd = ~rd;
         step(1, $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0,
              rm, int'($urandom_range(0, 3)), rd,
              $urandom_range(0, 6) == 0, 0);
      end
      drain();
      check("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
